// File: rtl/mem_arbiter_pkg.sv
// Shared core definitions for the fetch/data memory arbiter.
// Owner encoding for in-flight read responses and default widths.
package mem_arbiter_pkg;

  localparam int DW = 32;
  localparam int CW = 3;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

endpackage

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between fetch and data requesters.
// Data wins by default; a starvation counter forces fetch through.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  parameter int AW         = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_gnt,
  output logic          i_rvalid,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic [AW-1:0] d_addr,
  input  logic          d_wen,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          m_en,
  output logic [AW-1:0] m_addr,
  output logic          m_wen,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata
);

  localparam logic [CW-1:0] SMAX = CW'(STARVE_MAX);

  owner_e        own;
  owner_e        own_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          starve;
  logic          i_g;
  logic          d_g;
  logic          st;

  // Grants are forced low while reset is held.
  always_comb begin
    starve = i_req && (cnt == SMAX);
    d_g    = rst_n && d_req && !starve;
    i_g    = rst_n && i_req && !d_g;
    st     = d_g && d_wen;
  end

  assign i_gnt   = i_g;
  assign d_gnt   = d_g;
  assign m_en    = i_g | d_g;
  assign m_wen   = st;
  assign m_wdata = st ? d_wdata : '0;

  always_comb begin
    m_addr = '0;
    unique case (1'b1)
      d_g:     m_addr = d_addr;
      i_g:     m_addr = i_addr;
      default: m_addr = '0;
    endcase
  end

  always_comb begin
    own_nxt = OWN_NONE;
    unique case (1'b1)
      i_g:          own_nxt = OWN_I;
      d_g && !d_wen: own_nxt = OWN_D;
      default:      own_nxt = OWN_NONE;
    endcase
  end

  always_comb begin
    cnt_nxt = cnt;
    if (!i_req || i_g) begin
      cnt_nxt = '0;
    end else if (d_g && (cnt != '1)) begin
      cnt_nxt = cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      own <= OWN_NONE;
      cnt <= '0;
    end else begin
      own <= own_nxt;
      cnt <= cnt_nxt;
    end
  end

  assign i_rvalid = (own == OWN_I);
  assign d_rvalid = (own == OWN_D);
  assign i_rdata  = i_rvalid ? m_rdata : '0;
  assign d_rdata  = d_rvalid ? m_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter with a behavioural memory and
// grant/response reference model.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int SM = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_req = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic          i_gnt;
  logic          i_rvalid;
  logic [31:0]   i_rdata;
  logic          d_req = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic          d_wen = 1'b0;
  logic [31:0]   d_wdata = '0;
  logic          d_gnt;
  logic          d_rvalid;
  logic [31:0]   d_rdata;
  logic          m_en;
  logic [AW-1:0] m_addr;
  logic          m_wen;
  logic [31:0]   m_wdata;
  logic [31:0]   m_rdata = '0;

  mem_arbiter #(.STARVE_MAX(SM), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt),
    .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_addr(d_addr), .d_wen(d_wen),
    .d_wdata(d_wdata), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_en(m_en), .m_addr(m_addr), .m_wen(m_wen),
    .m_wdata(m_wdata), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  bit [31:0] mem [bit [31:0]];

  // model: pending response owner (0 none, 1 fetch, 2 data)
  int        pend = 0;
  logic [31:0] pend_data = '0;
  int        wait_cnt = 0;
  bit        last_i, last_d;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check_zero(string tag);
    check({tag, "_i_gnt"}, i_gnt, 0);
    check({tag, "_d_gnt"}, d_gnt, 0);
    check({tag, "_i_rv"}, i_rvalid, 0);
    check({tag, "_d_rv"}, d_rvalid, 0);
    check({tag, "_i_rd"}, i_rdata, 0);
    check({tag, "_d_rd"}, d_rdata, 0);
    check({tag, "_m_en"}, m_en, 0);
    check({tag, "_m_addr"}, m_addr, 0);
    check({tag, "_m_wen"}, m_wen, 0);
    check({tag, "_m_wdata"}, m_wdata, 0);
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic step();
    bit ei, ed;
    #1;
    ed = d_req && !(i_req && wait_cnt == SM);
    ei = i_req && !ed;
    check("i_gnt", i_gnt, ei);
    check("d_gnt", d_gnt, ed);
    check("one_hot", i_gnt & d_gnt, 0);
    check("m_en", m_en, ei | ed);
    check("m_wen", m_wen, ed && d_wen);
    if (ed) check("m_addr_d", m_addr, d_addr);
    else if (ei) check("m_addr_i", m_addr, i_addr);
    if (ed && d_wen) check("m_wdata", m_wdata, d_wdata);
    check("i_rvalid", i_rvalid, pend == 1);
    check("d_rvalid", d_rvalid, pend == 2);
    check("i_rdata", i_rdata, (pend == 1) ? pend_data : 32'h0);
    check("d_rdata", d_rdata, (pend == 2) ? pend_data : 32'h0);
    last_i = ei;
    last_d = ed;
    @(posedge clk);
    if (ed && d_wen) mem[d_addr] = d_wdata;
    if (ei) begin
      pend = 1;
      pend_data = mem_rd(i_addr);
    end else if (ed && !d_wen) begin
      pend = 2;
      pend_data = mem_rd(d_addr);
    end else begin
      pend = 0;
    end
    m_rdata = (pend != 0) ? pend_data : $urandom;
    if (!i_req || ei) wait_cnt = 0;
    else if (ed && wait_cnt < 7) wait_cnt++;
    @(negedge clk);
  endtask

  task automatic idle();
    i_req = 0;
    d_req = 0;
    step();
  endtask

  initial begin
    // reset with requests pending: everything must stay quiet
    i_req = 1;
    d_req = 1;
    d_wen = 1;
    d_addr = 32'h10;
    d_wdata = 32'h1234_5678;
    i_addr = 32'h20;
    m_rdata = 32'hFFFF_FFFF;
    #1;
    check_zero("rst");
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    i_req = 0;
    d_req = 0;
    d_wen = 0;
    idle();

    // fetch-only back to back
    i_req = 1; i_addr = 32'h0;
    #1 check("f0_gnt", i_gnt, 1);
    step();
    i_addr = 32'h4;
    #1 check("f4_gnt", i_gnt, 1);
    step();
    i_req = 0;
    #1 check("f4_rdata", i_rdata, mem_rd(32'h4));
    step();
    idle();

    // simultaneous: data first, then fetch
    i_req = 1; i_addr = 32'h8;
    d_req = 1; d_addr = 32'h100; d_wen = 0;
    #1 check("sim_d_first", d_gnt, 1);
    step();
    d_req = 0;
    #1 check("sim_i_next", i_gnt, 1);
    check("sim_d_rv", d_rvalid, 1);
    step();
    i_req = 0;
    #1 check("sim_i_rv", i_rvalid, 1);
    check("sim_i_rdata", i_rdata, mem_rd(32'h8));
    step();
    idle();

    // starvation pattern DDDDI repeating
    i_req = 1; i_addr = 32'h30;
    d_req = 1; d_addr = 32'h130; d_wen = 0;
    for (int k = 0; k < 15; k++) begin
      #1 check("starve_pat", d_gnt, (k % 5) != 4);
      step();
    end
    idle();
    idle();

    // store then load to same address
    d_req = 1; d_wen = 1; d_addr = 32'h200; d_wdata = 32'hDEAD_BEEF;
    #1 check("st_wen", m_wen, 1);
    step();
    d_wen = 0;
    #1 check("st_no_rv", d_rvalid, 0);
    step();
    d_req = 0;
    #1 check("ld_rdata", d_rdata, 32'hDEAD_BEEF);
    step();
    idle();

    // reset right after a fetch grant drops the response
    i_req = 1; i_addr = 32'h40;
    step();
    check("rst_pre_gnt", last_i, 1);
    i_req = 0;
    rst_n = 0;
    #1 check_zero("mid_rst");
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    pend = 0;
    wait_cnt = 0;
    #1 check("post_rst_rv", i_rvalid, 0);
    step();
    i_req = 1; i_addr = 32'h44;
    #1 check("post_rst_gnt", i_gnt, 1);
    step();
    idle();

    // random traffic with held requests
    i_req = 0;
    d_req = 0;
    for (int c = 0; c < 3000; c++) begin
      if (!i_req || last_i) begin
        i_req = ($urandom % 4) != 0;
        i_addr = {26'h0, 4'($urandom), 2'b00};
      end
      if (!d_req || last_d) begin
        d_req = ($urandom % 3) != 0;
        d_addr = {26'h0, 4'($urandom), 2'b00};
        d_wen = $urandom % 2;
        d_wdata = $urandom;
      end
      step();
    end
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
